// File: rtl/freq_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meas_pkg
// Purpose  : Shared types and the gate-length table for the frequency meter.
// Revision : 1.0  initial release
// ============================================================================
package freq_meas_pkg;

  localparam int unsigned CNT_W_DEFAULT = 40;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_e;

  // Gate window in system clock cycles; a window is never shorter than one cycle.
  function automatic logic [31:0] gate_cycles(input logic [1:0] sel, input int unsigned clk_hz);
    int unsigned q;
    case (sel)
      2'd0:    q = clk_hz;
      2'd1:    q = clk_hz / 10;
      2'd2:    q = clk_hz / 100;
      default: q = clk_hz / 1000;
    endcase
    if (q == 0) q = 1;
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_gate_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : gate_timer
// Purpose  : 32-bit load/down-counter timing the gate and settle intervals.
// Revision : 1.0  initial release
// ============================================================================
module gate_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] load_val,
  output logic [31:0] value,
  output logic        done
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // done marks the final cycle of the interval that was loaded
  assign value = cnt_q;
  assign done  = en && (cnt_q == 32'd1);

endmodule
`default_nettype wire

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_gate_ctrl
// Purpose  : Measurement sequencer: clear, gate, settle, latch, with result
//            handshake. Define FREQ_GATE_SEQ_EN to add the res_seq tag output.
// Revision : 1.0  initial release
// ============================================================================
module freq_gate_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 72000000,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk_72MHz,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_cont,
  input  logic [1:0]       cfg_gate_sel,
  input  logic [CNT_W-1:0] cnt_not,
  input  logic [CNT_W-1:0] cnt_etalon,
  input  logic             rd_ack,
  output logic             cnt_clr,
  output logic             gate_en,
  output logic             busy,
  output logic [CNT_W-1:0] res_not,
  output logic [CNT_W-1:0] res_etalon,
  output logic             res_valid,
`ifdef FREQ_GATE_SEQ_EN
  output logic [7:0]       res_seq,
`endif
  output logic             overrun
);

  localparam logic [31:0] c_gate_0    = gate_cycles(2'd0, CLK_HZ);
  localparam logic [31:0] c_gate_1    = gate_cycles(2'd1, CLK_HZ);
  localparam logic [31:0] c_gate_2    = gate_cycles(2'd2, CLK_HZ);
  localparam logic [31:0] c_gate_3    = gate_cycles(2'd3, CLK_HZ);
  localparam logic [31:0] c_settle_ld = (SETTLE_CYCLES == 0) ? 32'd1 : 32'(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic             tmr_load, tmr_en, tmr_done;
  logic [31:0]      tmr_load_val, tmr_value, gate_len;
  logic             latch, ack_eff;
  logic [CNT_W-1:0] res_not_q, res_not_d, res_etalon_q, res_etalon_d;
  logic             res_valid_q, res_valid_d, overrun_q, overrun_d;

  always_comb begin
    case (cfg_gate_sel)
      2'd0:    gate_len = c_gate_0;
      2'd1:    gate_len = c_gate_1;
      2'd2:    gate_len = c_gate_2;
      default: gate_len = c_gate_3;
    endcase
  end

  // Timer never wraps below zero even if an interval is left unfinished
  assign tmr_en = ((state_q == GATE) || (state_q == SETTLE)) && (tmr_value != 32'd0);

  gate_timer u_timer (
    .clk      (clk_72MHz),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    latch        = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CLEAR;
      CLEAR: begin
        tmr_load     = 1'b1;
        tmr_load_val = gate_len;
        state_d      = GATE;
      end
      GATE: if (tmr_done) begin
        tmr_load     = 1'b1;
        tmr_load_val = c_settle_ld;
        state_d      = SETTLE;
      end
      SETTLE: if (tmr_done) state_d = LATCH;
      LATCH: begin
        latch   = 1'b1;
        state_d = cfg_cont ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over every transition and suppresses the latch
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      latch        = 1'b0;
      tmr_load     = 1'b1;
      tmr_load_val = '0;
    end
  end

  assign ack_eff = rd_ack && res_valid_q;

  always_comb begin
    res_not_d    = res_not_q;
    res_etalon_d = res_etalon_q;
    res_valid_d  = res_valid_q;
    overrun_d    = overrun_q;
    if (latch) begin
      res_not_d    = cnt_not;
      res_etalon_d = cnt_etalon;
      res_valid_d  = 1'b1;
      if (res_valid_q && !rd_ack) begin
        overrun_d = 1'b1;
      end else if (ack_eff) begin
        overrun_d = 1'b0;
      end
    end else if (ack_eff) begin
      res_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_72MHz) begin
    if (rst) begin
      state_q      <= IDLE;
      res_not_q    <= '0;
      res_etalon_q <= '0;
      res_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_not_q    <= res_not_d;
      res_etalon_q <= res_etalon_d;
      res_valid_q  <= res_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef FREQ_GATE_SEQ_EN
  logic [7:0] seq_q, seq_d, res_seq_q, res_seq_d;

  always_comb begin
    seq_d     = seq_q;
    res_seq_d = res_seq_q;
    if (latch) begin
      res_seq_d = seq_q;
      seq_d     = seq_q + 8'd1;
    end
  end

  always_ff @(posedge clk_72MHz) begin
    if (rst) begin
      seq_q     <= '0;
      res_seq_q <= '0;
    end else begin
      seq_q     <= seq_d;
      res_seq_q <= res_seq_d;
    end
  end

  assign res_seq = res_seq_q;
`endif

  assign cnt_clr    = (state_q == CLEAR);
  assign gate_en    = (state_q == GATE);
  assign busy       = (state_q != IDLE);
  assign res_not    = res_not_q;
  assign res_etalon = res_etalon_q;
  assign res_valid  = res_valid_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_gate_ctrl
// Purpose  : Self-checking bench for freq_gate_ctrl (CLK_HZ=1000, settle 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_freq_gate_ctrl;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned CW     = 40;

  logic          clk = 1'b0;
  logic          rst, start, abort, cfg_cont, rd_ack;
  logic [1:0]    cfg_gate_sel;
  logic [CW-1:0] cnt_not, cnt_etalon;
  logic          cnt_clr, gate_en, busy, res_valid, overrun;
  logic [CW-1:0] res_not, res_etalon;
`ifdef FREQ_GATE_SEQ_EN
  logic [7:0]    res_seq;
`endif

  always #5 clk = ~clk;

  freq_gate_ctrl #(
    .CLK_HZ        (CLK_HZ),
    .CNT_W         (CW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk_72MHz    (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_cont     (cfg_cont),
    .cfg_gate_sel (cfg_gate_sel),
    .cnt_not      (cnt_not),
    .cnt_etalon   (cnt_etalon),
    .rd_ack       (rd_ack),
    .cnt_clr      (cnt_clr),
    .gate_en      (gate_en),
    .busy         (busy),
    .res_not      (res_not),
    .res_etalon   (res_etalon),
    .res_valid    (res_valid),
`ifdef FREQ_GATE_SEQ_EN
    .res_seq      (res_seq),
`endif
    .overrun      (overrun)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int gate_cnt = 0;
  int clr_cnt  = 0;
  int gtab [4] = '{1000, 100, 10, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a measurement is a cycle index k from its clear cycle (k=0).
  // Gate occupies k=1..G, settle k=G+1..G+S, latch at k=G+S+1.
  bit            m_active, m_valid, m_ovr;
  int            m_k, m_G, m_seq_next;
  logic [CW-1:0] m_not, m_et;
  logic [7:0]    m_seq;

  always @(posedge clk) begin : model
    bit latch_now;
    latch_now = 1'b0;
    if (rst) begin
      m_active = 0; m_k = 0; m_G = 1; m_valid = 0; m_ovr = 0;
      m_not = '0; m_et = '0; m_seq = '0; m_seq_next = 0;
    end else begin
      if (m_active) begin
        if (abort) begin
          m_active = 0;
        end else begin
          if (m_k == 0) m_G = gtab[cfg_gate_sel];
          if (m_k == m_G + SETTLE + 1) begin
            latch_now = 1'b1;
            if (cfg_cont) m_k = 0;
            else m_active = 0;
          end else begin
            m_k++;
          end
        end
      end else if (start) begin
        m_active = 1; m_k = 0;
      end
      if (latch_now) begin
        m_ovr      = m_valid && !rd_ack;
        m_valid    = 1;
        m_not      = cnt_not;
        m_et       = cnt_etalon;
        m_seq      = 8'(m_seq_next);
        m_seq_next = (m_seq_next + 1) % 256;
      end else if (rd_ack && m_valid) begin
        m_valid = 0; m_ovr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cnt_clr",    cnt_clr,    m_active && m_k == 0);
      check("gate_en",    gate_en,    m_active && m_k >= 1 && m_k <= m_G);
      check("busy",       busy,       m_active);
      check("res_valid",  res_valid,  m_valid);
      check("overrun",    overrun,    m_ovr);
      check("res_not",    res_not,    m_not);
      check("res_etalon", res_etalon, m_et);
`ifdef FREQ_GATE_SEQ_EN
      check("res_seq",    res_seq,    m_seq);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (gate_en) gate_cnt++;
    if (cnt_clr) clr_cnt++;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!res_valid && n < maxc) begin
      tick();
      n++;
    end
    check("valid_wait", res_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || res_valid) && n < 300) begin
      rd_ack = res_valid;
      tick();
      rd_ack = 0;
      n++;
    end
    check("drain_idle", busy || res_valid, 0);
  endtask

  initial begin
    int n, g0, c0;
    rst = 1; start = 0; abort = 0; cfg_cont = 0; rd_ack = 0;
    cfg_gate_sel = 0; cnt_not = '0; cnt_etalon = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_gate", gate_en, 0);
    check("rst_valid", res_valid, 0);
    check("rst_res_not", res_not, 0);
    rst = 0;
    tick();

    // single shot, sel=2 -> 10-cycle gate
    cfg_gate_sel = 2; cnt_not = 37; cnt_etalon = 41;
    g0 = gate_cnt; c0 = clr_cnt;
    start = 1; tick(); start = 0;
    wait_valid(200, n);
    check("ss_latency", n, 16);
    check("ss_gate_len", gate_cnt - g0, 10);
    check("ss_clr_len", clr_cnt - c0, 1);
    check("ss_res_not", res_not, 37);
    check("ss_res_etalon", res_etalon, 41);
    check("ss_busy_after", busy, 0);
    rd_ack = 1; tick(); rd_ack = 0;
    check("ss_ack_clears", res_valid, 0);

    // continuous with ack, sel=3 -> 1-cycle gate
    cfg_cont = 1; cfg_gate_sel = 3; cnt_not = 100; cnt_etalon = 200;
    g0 = gate_cnt;
    start = 1; tick(); start = 0;
    for (int r = 0; r < 3; r++) begin
      wait_valid(50, n);
      check("ca_gate_per_meas", gate_cnt - g0, 1);
      check("ca_overrun", overrun, 0);
      check("ca_res_not", res_not, 100 + r);
      check("ca_res_etalon", res_etalon, 200 + r);
      g0 = gate_cnt;
      cnt_not = CW'(101 + r); cnt_etalon = CW'(201 + r);
      tick(); rd_ack = 1; tick(); rd_ack = 0;
    end
    cfg_cont = 0;
    drain();

    // overrun: continuous, never acked
    cfg_cont = 1; cfg_gate_sel = 3; cnt_not = 555; cnt_etalon = 666;
    start = 1; tick(); start = 0;
    n = 0;
    while (!overrun && n < 50) begin tick(); n++; end
    check("ov_set", overrun, 1);
    check("ov_valid", res_valid, 1);
    cfg_cont = 0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    check("ov_idle", busy, 0);
    rd_ack = 1; tick(); rd_ack = 0;
    check("ov_clr_valid", res_valid, 0);
    check("ov_clr_ovr", overrun, 0);

    // abort 50 cycles into a 100-cycle gate
    cfg_gate_sel = 1; cnt_not = 7; cnt_etalon = 8;
    start = 1; tick(); start = 0;
    repeat (50) tick();
    check("ab_in_gate", gate_en, 1);
    abort = 1; tick(); abort = 0;
    check("ab_gate", gate_en, 0);
    check("ab_busy", busy, 0);
    check("ab_valid", res_valid, 0);
    check("ab_res_not", res_not, 555);
    check("ab_res_etalon", res_etalon, 666);

    // reset at gate cycle 5, then a clean measurement
    cfg_gate_sel = 2;
    start = 1; tick(); start = 0;
    repeat (5) tick();
    rst = 1; tick(); rst = 0;
    check("mr_gate", gate_en, 0);
    check("mr_clr", cnt_clr, 0);
    check("mr_busy", busy, 0);
    check("mr_res_not", res_not, 0);
    check("mr_res_etalon", res_etalon, 0);
    cnt_not = 9; cnt_etalon = 11;
    start = 1; tick(); start = 0;
    wait_valid(200, n);
    check("mr_latency", n, 16);
    check("mr_res_not2", res_not, 9);
    check("mr_res_etalon2", res_etalon, 11);
    drain();

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom % 6) == 0;
      abort  = ($urandom % 50) == 0;
      rd_ack = ($urandom % 3) == 0;
      rst    = ($urandom % 700) == 0;
      if (($urandom % 40) == 0) cfg_cont = 1'($urandom % 2);
      cfg_gate_sel = (($urandom % 10) == 0) ? 2'd1 : 2'($urandom_range(2, 3));
      cnt_not      = CW'({$urandom, $urandom});
      cnt_etalon   = CW'({$urandom, $urandom});
      tick();
    end
    start = 0; abort = 0; rd_ack = 0; rst = 0; cfg_cont = 0;
    drain();

`ifdef FREQ_GATE_SEQ_EN
    rst = 1; tick(); rst = 0;
    cfg_cont = 1; cfg_gate_sel = 3;
    start = 1; tick(); start = 0;
    for (int r = 0; r < 257; r++) begin
      wait_valid(50, n);
      check("seq_tag", res_seq, r % 256);
      tick(); rd_ack = 1; tick(); rd_ack = 0;
    end
    cfg_cont = 0;
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
